// File: rtl/lpce_pkg.sv
// lpce_pkg: shared state encoding, sync defaults and CRC-8 constants
// for the LPCE serial receive path.
package lpce_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_MARK = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } lpce_state_e;

    localparam int         LPCE_SYNC_W    = 10;
    localparam logic [9:0] LPCE_SYNC_HEAD = 10'b1010101010;
    localparam logic [7:0] LPCE_CRC8_POLY = 8'h07;
    localparam logic [7:0] LPCE_CRC8_INIT = 8'h00;

    // One MSB-first bit of CRC-8 division.
    function automatic logic [7:0] lpce_crc8_step(
        input logic [7:0] crc,
        input logic       b
    );
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? LPCE_CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/lpce_crc8.sv
// lpce_crc8: serial CRC-8 accumulator, one data bit per enabled cycle,
// synchronous clear back to the init value.
module lpce_crc8
    import lpce_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = LPCE_CRC8_INIT;
        end else if (en_i) begin
            crc_d = lpce_crc8_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            crc_q <= LPCE_CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/lpce_rx_deframer.sv
// lpce_rx_deframer: sync hunt, marker-checked byte slots, single-entry
// valid/ready output register. LPCE_RX_CRC8_EN adds a trailing CRC-8 slot.
module lpce_rx_deframer
    import lpce_pkg::*;
#(
    parameter int                NBYTES    = 16,
    parameter int                SYNC_W    = LPCE_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_HEAD = SYNC_W'(LPCE_SYNC_HEAD),
    parameter logic              MARK_VAL  = 1'b0
) (
    input  logic                LPCE_CLKi,
    input  logic                LPCE_RSTn,
    input  logic                LPCE_DATi,
    output logic                SYNC,
    output logic [NBYTES*8-1:0] OUT_DATA,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic                FRAME_ERR,
    output logic                DROP,
    output logic [15:0]         FRAME_CNT
);

    localparam int PW  = NBYTES * 8;
    localparam int BCW = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
`ifdef LPCE_RX_CRC8_EN
    localparam int SHW = PW;
    localparam logic [BCW-1:0] CRC_SLOT = BCW'(NBYTES);
`else
    // Last payload bit goes straight from the line into the output.
    localparam int SHW = PW - 1;
`endif

    lpce_state_e       state_q, state_d;
    logic [SYNC_W-1:0] shreg_q, shreg_d;
    logic [2:0]        bit_q, bit_d;
    logic [BCW-1:0]    byte_q, byte_d;
    logic [SHW-1:0]    pay_q, pay_d;
    logic [PW-1:0]     data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              sync_hit;
    logic              mark_bad;
    logic              byte_end;
    logic              last_byte;
    logic              frame_done;
    logic              frame_bad;
    logic [PW-1:0]     frame_pay;

    assign sync_hit  = (state_q == ST_HUNT) &&
                       ({shreg_q[SYNC_W-2:0], LPCE_DATi} == SYNC_HEAD);
    assign mark_bad  = (state_q == ST_MARK) && (LPCE_DATi != MARK_VAL);
    assign byte_end  = (bit_q == 3'd7);
    assign last_byte = (byte_q == LAST_BYTE);

`ifdef LPCE_RX_CRC8_EN
    logic [7:0] crc;
    logic [6:0] rcrc_q, rcrc_d;
    logic       crc_end;
    logic       crc_hit;

    lpce_crc8 u_crc (
        .clk_i   (LPCE_CLKi),
        .rst_n_i (LPCE_RSTn),
        .clr_i   (state_q == ST_HUNT),
        .en_i    (state_q == ST_DATA),
        .bit_i   (LPCE_DATi),
        .crc_o   (crc)
    );

    assign rcrc_d     = (state_q == ST_CRC) ? {rcrc_q[5:0], LPCE_DATi} : rcrc_q;
    assign crc_end    = (state_q == ST_CRC) && byte_end;
    assign crc_hit    = ({rcrc_q, LPCE_DATi} == crc);
    assign frame_done = crc_end && crc_hit;
    assign frame_bad  = crc_end && !crc_hit;
    assign frame_pay  = pay_q;

    always_ff @(posedge LPCE_CLKi) begin
        if (!LPCE_RSTn) begin
            rcrc_q <= '0;
        end else begin
            rcrc_q <= rcrc_d;
        end
    end
`else
    assign frame_done = (state_q == ST_DATA) && byte_end && last_byte;
    assign frame_bad  = 1'b0;
    assign frame_pay  = {pay_q, LPCE_DATi};
`endif

    always_ff @(posedge LPCE_CLKi) begin
        if (!LPCE_RSTn) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HUNT: if (sync_hit) state_d = ST_MARK;
            ST_MARK: begin
                if (mark_bad) state_d = ST_HUNT;
`ifdef LPCE_RX_CRC8_EN
                else if (byte_q == CRC_SLOT) state_d = ST_CRC;
`endif
                else state_d = ST_DATA;
            end
            ST_DATA: begin
                if (byte_end) begin
`ifdef LPCE_RX_CRC8_EN
                    state_d = ST_MARK;
`else
                    state_d = last_byte ? ST_HUNT : ST_MARK;
`endif
                end
            end
`ifdef LPCE_RX_CRC8_EN
            ST_CRC: if (byte_end) state_d = ST_HUNT;
`endif
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        shreg_d = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pay_d   = pay_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = mark_bad || frame_bad;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
        if ((state_q == ST_HUNT) && !sync_hit) begin
            shreg_d = {shreg_q[SYNC_W-2:0], LPCE_DATi};
        end
        if (state_q == ST_DATA) begin
            pay_d = {pay_q[SHW-2:0], LPCE_DATi};
            bit_d = bit_q + 3'd1;
            if (byte_end) byte_d = byte_q + 1'b1;
        end
        if (state_q == ST_CRC) bit_d = bit_q + 3'd1;
        if (state_d == ST_HUNT) begin
            bit_d  = '0;
            byte_d = '0;
        end
        if (valid_q && OUT_READY) valid_d = 1'b0;
        // A held, unaccepted frame wins over a newly completed one.
        if (frame_done) begin
            if (valid_q && !OUT_READY) begin
                drop_d = 1'b1;
            end else begin
                data_d  = frame_pay;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge LPCE_CLKi) begin
        if (!LPCE_RSTn) begin
            shreg_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            pay_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            pay_q   <= pay_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign SYNC      = (state_q != ST_HUNT);
    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign FRAME_ERR = err_q;
    assign DROP      = drop_q;
    assign FRAME_CNT = cnt_q;

endmodule

// File: doc/lpce_rx_deframer.md
LPCE_RX_DEFRAMER -- requirements
Module: lpce_rx_deframer

Interface
REQ-001 SHALL have parameter NBYTES, default 16, payload bytes per frame (1..32).
REQ-002 SHALL have parameter SYNC_W, default 10, sync head length in bits.
REQ-003 SHALL have parameter SYNC_HEAD, default 10'b1010101010, sync head pattern, MSB received first.
REQ-004 SHALL have parameter MARK_VAL, default 1'b0, required value of the marker bit before each byte.
REQ-005 Ports: LPCE_CLKi  in  1  sole clock, rising edge; one clock, synchronous active-low reset.
REQ-006 Ports: LPCE_RSTn  in  1  reset, synchronous, active-low.
REQ-007 Ports: LPCE_DATi  in  1  serial line data, sampled each rising edge.
REQ-008 Ports: SYNC  out  1  high while in-frame (MARK/DATA/CRC states), suitable for an LED.
REQ-009 Ports: OUT_DATA  out  NBYTES*8  frame payload, first-received byte in MSBs.
REQ-010 Ports: OUT_VALID / OUT_READY  out/in  1/1  valid-ready handshake on OUT_DATA.
REQ-011 Ports: FRAME_ERR  out  1  one-cycle pulse on marker or CRC error.
REQ-012 Ports: DROP  out  1  one-cycle pulse when a good frame is lost to backpressure.
REQ-013 Ports: FRAME_CNT  out  16  count of frames delivered into the output register, wraps at 0xFFFF->0.

Function
REQ-014 Frame: SYNC_HEAD, then NBYTES slots of {1 marker bit, 8 data bits MSB first}; no trailer.
REQ-015 States: HUNT, MARK, DATA, CRC (macro only); 3-bit bit counter, byte counter sized for NBYTES+1.
REQ-016 HUNT: SYNC_W-bit shift register; on edge where {shreg[SYNC_W-2:0],LPCE_DATi}==SYNC_HEAD -> MARK.
REQ-017 MARK: sample == MARK_VAL -> DATA; else FRAME_ERR pulse, -> HUNT.
REQ-018 DATA: after 8th bit, next byte -> MARK; last payload byte -> HUNT (or CRC slot per REQ-026).
REQ-019 Entry to HUNT clears the shift register; a new sync needs SYNC_W fresh bits; no sync search mid-frame.
REQ-020 Completion: OUT_VALID and OUT_DATA update on the edge sampling the last frame bit (latency 0 cycles after last bit edge).
REQ-021 Output register single-entry: OUT_VALID holds with OUT_DATA stable until OUT_VALID && OUT_READY.
REQ-022 Completion while OUT_VALID=1 and OUT_READY=0: new frame discarded, DROP pulses, held data unchanged, FRAME_CNT unchanged.
REQ-023 Completion in the same cycle as a handshake: new frame loaded, OUT_VALID stays 1, FRAME_CNT increments.
REQ-024 FRAME_ERR and DROP never assert in the same cycle.

Reset
REQ-025 LPCE_RSTn low at an edge: state HUNT, shift register 0, counters 0, OUT_DATA 0, OUT_VALID 0, SYNC 0, FRAME_ERR 0, DROP 0, FRAME_CNT 0; mid-frame reset abandons the frame with no pulses.

Configuration
REQ-026 Macro LPCE_RX_CRC8_EN defined: one extra slot {marker, CRC byte} follows the payload; CRC-8 poly 0x07, init 0x00, over payload data bits only (markers excluded); mismatch -> frame discarded, FRAME_ERR pulse; match -> delivered per REQ-020..023.
REQ-027 Macro undefined: no CRC slot, no CRC logic; frame ends at last payload byte.

Structure
REQ-028 Shared package lpce_pkg SHALL hold state encoding, default SYNC_HEAD, SYNC_W, CRC8 polynomial and init.
REQ-029 Serial CRC SHALL be sub-module lpce_crc8 (clear, bit-enable, bit-in, 8-bit crc out), instantiated only under LPCE_RX_CRC8_EN.

Verification (NBYTES=4)
REQ-030 Sync 1010101010 + slots 0/A5, 0/3C, 0/FF, 0/00, OUT_READY=1 -> OUT_VALID one cycle with OUT_DATA=0xA53CFF00, FRAME_CNT=1.
REQ-031 Same frame with second marker=1 -> FRAME_ERR pulse at that bit, SYNC low next cycle, no OUT_VALID, FRAME_CNT=0.
REQ-032 OUT_READY=0, two good frames 0x11223344 then 0x55667788 -> OUT_DATA stays 0x11223344, DROP pulses once, FRAME_CNT=1.
REQ-033 Payload pattern 1010101010 embedded in DATA bits -> no resync; frame delivered intact.
REQ-034 LPCE_RSTn low for one cycle during byte 2 -> next cycle all outputs 0, state HUNT; following clean frame delivered correctly.
REQ-035 LPCE_RX_CRC8_EN: payload 01 02 03 04 + CRC 0xE3 -> delivered 0x01020304; CRC 0xE2 -> FRAME_ERR pulse, no OUT_VALID.
